// File: rtl/ahb_arbiter_2m.sv
// ---------------------------------------------------------------------------
// ahb_arbiter_2m
//
// Two-master AHB-Lite arbiter that lets two masters share the single AHB
// slave port of the AHB-to-APB bridge. One master owns the address phase at
// a time. Its address and control signals are muxed to the bridge. Write data
// is muxed by the data-phase owner, so a pending data phase always completes
// with the data of the master that issued it. Ownership is handed over after
// a bounded tenure, so neither master can monopolise the APB side.
//
// Parameters
//   MAX_BEATS       accepted transfers an owner may issue while the other
//                   master is waiting, before a forced handover (1..15)
//   DEFAULT_MASTER  park master, granted when nobody requests (0 or 1)
//
// Ports
//   Hclk, Hresetn           bus clock, asynchronous active-low reset
//   Hbusreq[1:0]            bus request, bit n from master n
//   Haddr0/1, Htrans0/1,
//   Hwrite0/1, Hwdata0/1    per-master address, control and write data
//   Hreadyout               ready from the bridge
//   Hgrant[1:0]             one-hot grant (address-phase owner)
//   Hmaster                 index of the address-phase owner
//   Haddr, Htrans, Hwrite   owner's address phase, to the bridge
//   Hwdata                  data-phase owner's write data, to the bridge
//   Hreadyin                to the bridge, equal to Hreadyout
//
// Optional feature (macro ARB_LOCK_EN)
//   Adds Hlock0/Hlock1 inputs and the Hmastlock output. While the owner
//   asserts its lock, the owner keeps the bus: no handover and no parking.
//   Tenure keeps counting but saturates.
// ---------------------------------------------------------------------------
module ahb_arbiter_2m #(
  parameter int unsigned MAX_BEATS      = 4,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic [1:0]  Hbusreq,
`ifdef ARB_LOCK_EN
  input  logic        Hlock0,
  input  logic        Hlock1,
  output logic        Hmastlock,
`endif
  input  logic [31:0] Haddr0,
  input  logic [31:0] Haddr1,
  input  logic [1:0]  Htrans0,
  input  logic [1:0]  Htrans1,
  input  logic        Hwrite0,
  input  logic        Hwrite1,
  input  logic [31:0] Hwdata0,
  input  logic [31:0] Hwdata1,
  input  logic        Hreadyout,
  output logic [1:0]  Hgrant,
  output logic        Hmaster,
  output logic [31:0] Haddr,
  output logic [1:0]  Htrans,
  output logic        Hwrite,
  output logic [31:0] Hwdata,
  output logic        Hreadyin
);

  localparam logic       DEF_M  = (DEFAULT_MASTER != 0);
  localparam logic [3:0] MAX_T  = 4'(MAX_BEATS);
  localparam logic [1:0] T_IDLE = 2'b00;

  // Tenure counter increment that sticks at MAX_BEATS.
  function automatic logic [3:0] sat_inc(input logic [3:0] t);
    return (t >= MAX_T) ? MAX_T : t + 4'd1;
  endfunction

  logic       owner;
  logic       data_owner;
  logic [3:0] tenure;

  logic       other;
  logic [1:0] trans_o;
  logic       req_o;
  logic       req_x;
  logic       lock_o;
  logic       beat;
  logic [3:0] tenure_nxt;
  logic       cond_a;
  logic       cond_b;
  logic       cond_c;
  logic       handover;
  logic       park;

  // Arbitration decision for the next ready edge.
  always_comb begin
    other   = ~owner;
    trans_o = owner ? Htrans1 : Htrans0;
    req_o   = Hbusreq[owner];
    req_x   = Hbusreq[other];
`ifdef ARB_LOCK_EN
    lock_o  = owner ? Hlock1 : Hlock0;
`else
    lock_o  = 1'b0;
`endif
    // Only NONSEQ/SEQ are beats; BUSY keeps the bus but does not consume tenure.
    beat       = trans_o[1];
    tenure_nxt = beat ? sat_inc(tenure) : tenure;

    cond_a = (trans_o == T_IDLE);
    cond_b = ~req_o;
    // Tenure includes the beat accepted on this edge, so the owner gets
    // exactly MAX_BEATS beats while the other master waits.
    cond_c = (tenure_nxt >= MAX_T);

    handover = req_x & ~lock_o & (cond_a | cond_b | cond_c);
    park     = (Hbusreq == 2'b00) & (owner != DEF_M) & cond_a & ~lock_o;
  end

  // All state only advances on a ready edge; a stalled transfer freezes
  // ownership, the data-phase select and tenure.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      owner      <= DEF_M;
      data_owner <= DEF_M;
      tenure     <= 4'd0;
    end else if (Hreadyout) begin
      data_owner <= owner;
      if (handover) begin
        owner  <= other;
        tenure <= 4'd0;
      end else if (park) begin
        owner  <= DEF_M;
        tenure <= 4'd0;
      end else begin
        tenure <= tenure_nxt;
      end
    end
  end

  // Bus muxing towards the bridge.
  always_comb begin
    Hgrant   = owner ? 2'b10 : 2'b01;
    Hmaster  = owner;
    Haddr    = owner ? Haddr1  : Haddr0;
    Hwrite   = owner ? Hwrite1 : Hwrite0;
    // No transfer may be presented while the bus is in reset.
    Htrans   = Hresetn ? trans_o : T_IDLE;
    Hwdata   = data_owner ? Hwdata1 : Hwdata0;
    Hreadyin = Hreadyout;
`ifdef ARB_LOCK_EN
    Hmastlock = Hresetn ? lock_o : 1'b0;
`endif
  end

endmodule

// File: tb/tb_ahb_arbiter_2m.sv
module tb_ahb_arbiter_2m;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic [1:0]  Hbusreq;
  logic [31:0] Haddr0, Haddr1, Hwdata0, Hwdata1;
  logic [1:0]  Htrans0, Htrans1;
  logic        Hwrite0, Hwrite1, Hreadyout;
  logic [1:0]  Hgrant;
  logic        Hmaster;
  logic [31:0] Haddr, Hwdata;
  logic [1:0]  Htrans;
  logic        Hwrite, Hreadyin;
`ifdef ARB_LOCK_EN
  logic        Hlock0, Hlock1, Hmastlock;
`endif

  localparam logic [31:0] A0 = 32'h0000_0A00;
  localparam logic [31:0] A1 = 32'h0000_0010;
  localparam logic [31:0] D0 = 32'hD0D0_0001;
  localparam logic [31:0] D1 = 32'h1111_0001;

  ahb_arbiter_2m #(.MAX_BEATS(4), .DEFAULT_MASTER(0)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hbusreq(Hbusreq),
`ifdef ARB_LOCK_EN
    .Hlock0(Hlock0), .Hlock1(Hlock1), .Hmastlock(Hmastlock),
`endif
    .Haddr0(Haddr0), .Haddr1(Haddr1), .Htrans0(Htrans0), .Htrans1(Htrans1),
    .Hwrite0(Hwrite0), .Hwrite1(Hwrite1), .Hwdata0(Hwdata0), .Hwdata1(Hwdata1),
    .Hreadyout(Hreadyout), .Hgrant(Hgrant), .Hmaster(Hmaster), .Haddr(Haddr),
    .Htrans(Htrans), .Hwrite(Hwrite), .Hwdata(Hwdata), .Hreadyin(Hreadyin)
  );

  always #5 Hclk = ~Hclk;

  typedef struct packed {
    logic [1:0]  g;
    logic        m;
    logic [31:0] a;
    logic [1:0]  t;
    logic        w;
    logic [31:0] d;
    logic        r;
    logic        l;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  event  ev_chk;

  function automatic void chk(string nm, string fld, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, expv);
    end
  endfunction

  // Monitor: every output snapshot queued by the stimulus is compared at the
  // next falling edge (or immediately on ev_chk for asynchronous events).
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge Hclk or ev_chk);
      while (q.size() > 0) begin
        e  = q.pop_front();
        nm = nq.pop_front();
        chk(nm, "Hgrant",   32'(Hgrant),   32'(e.g));
        chk(nm, "Hmaster",  32'(Hmaster),  32'(e.m));
        chk(nm, "Haddr",    Haddr,         e.a);
        chk(nm, "Htrans",   32'(Htrans),   32'(e.t));
        chk(nm, "Hwrite",   32'(Hwrite),   32'(e.w));
        chk(nm, "Hwdata",   Hwdata,        e.d);
        chk(nm, "Hreadyin", 32'(Hreadyin), 32'(e.r));
`ifdef ARB_LOCK_EN
        chk(nm, "Hmastlock", 32'(Hmastlock), 32'(e.l));
`endif
      end
    end
  end

  task automatic cyc();
    @(posedge Hclk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [1:0] g, input logic m,
                            input logic [31:0] a, input logic [1:0] t, input logic w,
                            input logic [31:0] d, input logic l = 1'b0);
    exp_t e;
    e.g = g; e.m = m; e.a = a; e.t = t; e.w = w; e.d = d; e.r = Hreadyout; e.l = l;
    q.push_back(e);
    nq.push_back(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Hresetn = 1'b0; Hbusreq = 2'b00; Hreadyout = 1'b1;
    Haddr0 = A0; Haddr1 = A1; Hwdata0 = D0; Hwdata1 = D1;
    Htrans0 = 2'b10; Htrans1 = 2'b00; Hwrite0 = 1'b0; Hwrite1 = 1'b1;
`ifdef ARB_LOCK_EN
    Hlock0 = 1'b0; Hlock1 = 1'b0;
`endif

    // Reset: master0 parked, Htrans forced IDLE even though master0 drives NONSEQ.
    repeat (2) cyc();
    expect_out("rst", 2'b01, 1'b0, A0, 2'b00, 1'b0, D0);
    cyc(); Hresetn = 1'b1; Htrans0 = 2'b00;
    expect_out("rst_rel", 2'b01, 1'b0, A0, 2'b00, 1'b0, D0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      expect_out("idle_hold", 2'b01, 1'b0, A0, 2'b00, 1'b0, D0);
    end

    // Master1 requests while master0 is IDLE.
    cyc(); Hbusreq = 2'b10;
    expect_out("req1_pre", 2'b01, 1'b0, A0, 2'b00, 1'b0, D0);
    cyc(); Htrans1 = 2'b10;
    expect_out("req1_grant", 2'b10, 1'b1, A1, 2'b10, 1'b1, D0);
    cyc(); Htrans1 = 2'b00;
    expect_out("req1_data", 2'b10, 1'b1, A1, 2'b00, 1'b1, D1);

    // Master1 drops its request while IDLE: park back to master0.
    cyc(); Hbusreq = 2'b00;
    expect_out("park_pre", 2'b10, 1'b1, A1, 2'b00, 1'b1, D1);
    cyc();
    expect_out("park", 2'b01, 1'b0, A0, 2'b00, 1'b0, D1);
    cyc();
    expect_out("park_data", 2'b01, 1'b0, A0, 2'b00, 1'b0, D0);

    // Both request, master0 bursts; handover after its 4th accepted beat.
    cyc(); Hbusreq = 2'b11; Htrans0 = 2'b10; Htrans1 = 2'b10;
    expect_out("rr_beat1", 2'b01, 1'b0, A0, 2'b10, 1'b0, D0);
    for (int i = 0; i < 3; i++) begin
      cyc(); Htrans0 = 2'b11;
      expect_out("rr_beatn", 2'b01, 1'b0, A0, 2'b11, 1'b0, D0);
    end

    // Master1 now owns; master0's last data still selected. Stall 3 cycles
    // with a handover condition (master1 IDLE, master0 requesting).
    cyc(); Hreadyout = 1'b0; Htrans1 = 2'b00;
    expect_out("stall1", 2'b10, 1'b1, A1, 2'b00, 1'b1, D0);
    cyc();
    expect_out("stall2", 2'b10, 1'b1, A1, 2'b00, 1'b1, D0);
    cyc();
    expect_out("stall3", 2'b10, 1'b1, A1, 2'b00, 1'b1, D0);
    cyc(); Hreadyout = 1'b1;
    expect_out("stall_end", 2'b10, 1'b1, A1, 2'b00, 1'b1, D0);
    cyc(); Htrans0 = 2'b10;
    expect_out("stall_ho", 2'b01, 1'b0, A0, 2'b10, 1'b0, D1);

    // Hand to master1, start a write, then reset mid data phase.
    cyc(); Htrans0 = 2'b00;
    expect_out("pre_rst", 2'b01, 1'b0, A0, 2'b00, 1'b0, D0);
    cyc(); Htrans1 = 2'b10;
    expect_out("own1", 2'b10, 1'b1, A1, 2'b10, 1'b1, D0);
    cyc();
    expect_out("own1_data", 2'b10, 1'b1, A1, 2'b10, 1'b1, D1);
    @(negedge Hclk); #2;
    Hresetn = 1'b0;
    #1;
    expect_out("async_rst", 2'b01, 1'b0, A0, 2'b00, 1'b0, D0);
    -> ev_chk;
    cyc();
    cyc(); Hresetn = 1'b1; Hbusreq = 2'b00; Htrans0 = 2'b00; Htrans1 = 2'b00;
    expect_out("rst2_rel", 2'b01, 1'b0, A0, 2'b00, 1'b0, D0);

`ifdef ARB_LOCK_EN
    // Locked master0 keeps the bus for 8 beats despite both requesting.
    for (int i = 0; i < 8; i++) begin
      cyc(); Hlock0 = 1'b1; Hbusreq = 2'b11; Htrans0 = 2'b10;
      expect_out("lock", 2'b01, 1'b0, A0, 2'b10, 1'b0, D0, 1'b1);
    end
    cyc(); Hlock0 = 1'b0;
    expect_out("unlock", 2'b01, 1'b0, A0, 2'b10, 1'b0, D0, 1'b0);
    cyc();
    expect_out("lock_ho", 2'b10, 1'b1, A1, 2'b00, 1'b1, D0, 1'b0);
`endif

    repeat (2) @(negedge Hclk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter_2m.md
Name: ahb_arbiter_2m

Overview:
- Two-master AHB-Lite arbiter placed in front of bridge_top, so that two ahb_master instances share the single AHB slave port of the AHB-to-APB bridge.
- Grants the address phase to one master at a time.
- Muxes that master's address and control signals into the bridge.
- Muxes write data according to the data-phase owner.
- Enforces a bounded tenure so neither master starves the APB side.

Parameters:
- MAX_BEATS, 4: accepted transfers an owner may issue while the other master waits before a forced handover (1..15).
- DEFAULT_MASTER, 0: master that is granted when nobody requests (park master).

Ports:
- Hclk  in  1  bus clock
- Hresetn  in  1  asynchronous active-low reset
- Hbusreq  in  2  bus request, bit n from master n
- Haddr0, Haddr1  in  32  master address
- Htrans0, Htrans1  in  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- Hwrite0, Hwrite1  in  1  master direction
- Hwdata0, Hwdata1  in  32  master write data
- Hreadyout  in  1  ready from bridge_top
- Hgrant  out  2  one-hot grant
- Hmaster  out  1  index of the current address-phase owner
- Haddr  out  32  to the bridge
- Htrans  out  2  to the bridge
- Hwrite  out  1  to the bridge
- Hwdata  out  32  to the bridge
- Hreadyin  out  1  to the bridge; equals Hreadyout

Behaviour:
- Registered state:
  - owner (address-phase master)
  - data_owner (data-phase master)
  - tenure (4-bit count, saturating at MAX_BEATS)
- Reset values (Hresetn low, asynchronous):
  - owner = DEFAULT_MASTER, data_owner = DEFAULT_MASTER, tenure = 0
  - Hgrant = one-hot(DEFAULT_MASTER), Hmaster = DEFAULT_MASTER
  - Htrans output = 00 while in reset
- Combinational muxing:
  - Haddr/Htrans/Hwrite = selected by owner.
  - Hwdata = selected by data_owner.
  - Hgrant = one-hot(owner).
  - Hreadyin = Hreadyout.
- Every posedge Hclk with Hreadyout=1:
  - data_owner <= owner.
  - If the owner's Htrans is NONSEQ or SEQ: tenure increments, saturating at MAX_BEATS.
- Handover is evaluated only on posedge with Hreadyout=1. Let o = owner and x = the other master. Switch owner to x, and clear tenure, if Hbusreq[x]=1 and any of:
  - (a) Htrans_o == IDLE
  - (b) Hbusreq[o] == 0
  - (c) tenure, counting the beat accepted this cycle, >= MAX_BEATS
- Park: if Hbusreq == 00 and owner != DEFAULT_MASTER and Htrans_o == IDLE, owner <= DEFAULT_MASTER and tenure clears.
- Latency:
  - The new owner's address appears on Haddr in the cycle after the switching edge.
  - The old owner's pending data phase completes with its own Hwdata through data_owner.
- Hreadyout=0: owner, data_owner and tenure hold; no handover, irrespective of requests.
- Simultaneous requests: the current owner keeps the bus until (a), (b) or (c) holds. With two masters this gives round-robin.
- BUSY counts as non-IDLE for (a) but does not increment tenure.
- Reset mid-transfer: all state returns to reset values immediately; the in-flight data phase is abandoned.

Optional Feature:
- Macro ARB_LOCK_EN.
- When defined:
  - Adds inputs Hlock0 and Hlock1 (1 bit each) and output Hmastlock (1 bit, = Hlock of owner, reset 0).
  - While Hlock_o=1, conditions (b) and (c) are suppressed and no handover occurs.
  - Park is suppressed.
  - tenure still counts but saturates.
- When undefined: no lock ports; the arbitration rules above apply unchanged.

Test Plan:
- Reset with Hbusreq=00: Hgrant=01, Hmaster=0, Htrans=00. Release reset; state is unchanged over 5 cycles.
- Master1 requests while master0 IDLE (Hbusreq=10): Hgrant=10 one edge later. Haddr=Haddr1=0x0000_0010 on the following cycle; an APB write reaches Paddr=0x10.
- Both request, master0 issues back-to-back NONSEQ, MAX_BEATS=4: grant moves to master1 after master0's 4th accepted beat. Master0's 4th Hwdata still reaches the bridge in the next cycle.
- Hreadyout held low for 3 cycles during handover conditions: Hgrant, Hmaster and Hwdata select do not change until Hreadyout=1.
- Master1 owns the bus and drops Hbusreq with Htrans1=IDLE: parks to master0 (Hgrant=01) on the next ready edge.
- Reset asserted mid-write while owner=1: Hgrant=01 and data_owner=0 asynchronously. With ARB_LOCK_EN and Hlock0=1, 8 beats run with no handover despite Hbusreq=11.
